// File: rtl/mem_arbiter.sv
// Two-requester register<->memory access arbiter: IDLE/ISSUE/DONE sequencer with alternating priority.
// Optional completed-transaction counters are built only when MEM_ARB_PERF_EN is defined.
module mem_arbiter #(
    parameter  int unsigned ADDR_W = 8,
    parameter  int unsigned REG_W  = 2,
    localparam int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              op0,
    input  logic              op1,
    input  logic [REG_W-1:0]  reg0,
    input  logic [REG_W-1:0]  reg1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic              mem_run,
    output logic              mem_op,
    output logic [REG_W-1:0]  mem_reg,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic              op;
        logic [REG_W-1:0]  rsel;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    state_t state;
    state_t state_next;

    logic   any_req_c;
    logic   winner_c;
    logic   last_gnt;
    logic   last_gnt_next;
    cmd_t   cmd0_c;
    cmd_t   cmd1_c;
    cmd_t   cap;
    cmd_t   cap_next;

    logic   gnt0_d;
    logic   gnt1_d;
    logic   ack0_d;
    logic   ack1_d;
    logic   mem_run_d;
    logic   busy_d;
    cmd_t   mem_cmd_d;

    assign any_req_c = req0 | req1;
    // On contention the requester that did not win last time goes first.
    assign winner_c  = (req0 & req1) ? ~last_gnt : req1;
    assign cmd0_c    = {op0, reg0, addr0};
    assign cmd1_c    = {op1, reg1, addr1};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req_c) state_next = ISSUE;
            ISSUE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Winner and payload are latched only when leaving IDLE, so later input changes are ignored.
    always_comb begin
        last_gnt_next = last_gnt;
        cap_next      = cap;
        if ((state == IDLE) && any_req_c) begin
            last_gnt_next = winner_c;
            cap_next      = winner_c ? cmd1_c : cmd0_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
            cap      <= '0;
        end else begin
            last_gnt <= last_gnt_next;
            cap      <= cap_next;
        end
    end

    // Output decode from the upcoming state, so the registered outputs line up with the state.
    always_comb begin
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        mem_run_d = 1'b0;
        busy_d    = 1'b0;
        mem_cmd_d = '0;
        case (state_next)
            ISSUE: begin
                gnt0_d    = ~last_gnt_next;
                gnt1_d    = last_gnt_next;
                mem_run_d = 1'b1;
                busy_d    = 1'b1;
                mem_cmd_d = cap_next;
            end
            DONE: begin
                gnt0_d    = ~last_gnt_next;
                gnt1_d    = last_gnt_next;
                ack0_d    = ~last_gnt_next;
                ack1_d    = last_gnt_next;
                busy_d    = 1'b1;
                mem_cmd_d = cap_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            mem_run  <= 1'b0;
            busy     <= 1'b0;
            mem_op   <= 1'b0;
            mem_reg  <= '0;
            mem_addr <= '0;
        end else begin
            gnt0     <= gnt0_d;
            gnt1     <= gnt1_d;
            ack0     <= ack0_d;
            ack1     <= ack1_d;
            mem_run  <= mem_run_d;
            busy     <= busy_d;
            mem_op   <= mem_cmd_d.op;
            mem_reg  <= mem_cmd_d.rsel;
            mem_addr <= mem_cmd_d.addr;
        end
    end

`ifdef MEM_ARB_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating per-requester completion counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (ack0 && (cnt0 != CNT_MAX)) cnt0 <= cnt0 + CNT_W'(1);
            if (ack1 && (cnt1 != CNT_MAX)) cnt1 <= cnt1 + CNT_W'(1);
        end
    end
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-schedule model.
module tb_mem_arbiter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0  = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
    logic [1:0] reg0  = '0, reg1 = '0;
    logic [7:0] addr0 = '0, addr1 = '0;
    logic       gnt0, gnt1, ack0, ack1, mem_run, mem_op, busy;
    logic [1:0] mem_reg;
    logic [7:0] mem_addr, cnt0, cnt1;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .reg0(reg0), .reg1(reg1), .addr0(addr0), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .mem_run(mem_run), .mem_op(mem_op), .mem_reg(mem_reg), .mem_addr(mem_addr),
        .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: one scheduled transaction (issue cycle, done cycle, owner, payload).
    int         issue_cyc = -10, done_cyc = -10, free_at = 0;
    logic       m_owner = 1'b0, m_last = 1'b1, m_op = 1'b0;
    logic [1:0] m_reg = '0;
    logic [7:0] m_addr = '0;
    int         m_cnt0 = 0, m_cnt1 = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_bundle();
        return 32'({gnt0, gnt1, ack0, ack1, mem_run, busy, mem_op, mem_reg, mem_addr});
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef MEM_ARB_PERF_EN
        return 32'({8'(m_cnt0), 8'(m_cnt1)});
`else
        return 32'h0;
`endif
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : v;
    endfunction

    // One clock: drive inputs after the edge, compare at the falling edge, then advance the model.
    task automatic step(input logic r0, input logic o0, input logic [1:0] g0, input logic [7:0] a0,
                        input logic r1, input logic o1, input logic [1:0] g1, input logic [7:0] a1);
        logic iss, dn, act, w;
        @(posedge clk);
        #1;
        req0 = r0; op0 = o0; reg0 = g0; addr0 = a0;
        req1 = r1; op1 = o1; reg1 = g1; addr1 = a1;
        @(negedge clk);
        cyc++;
        iss = (cyc == issue_cyc);
        dn  = (cyc == done_cyc);
        act = iss | dn;
        check_eq("bus", obs_bundle(),
                 32'({act & ~m_owner, act & m_owner, dn & ~m_owner, dn & m_owner, iss, act,
                      act & m_op, act ? m_reg : 2'b00, act ? m_addr : 8'h00}));
        check_eq("cnt", 32'({cnt0, cnt1}), exp_cnt());
        if (dn) begin
            if (m_owner) m_cnt1 = sat_inc(m_cnt1);
            else         m_cnt0 = sat_inc(m_cnt0);
        end
        if ((cyc >= free_at) && (r0 || r1)) begin
            w         = (r0 && r1) ? ~m_last : r1;
            m_last    = w;
            m_owner   = w;
            m_op      = w ? o1 : o0;
            m_reg     = w ? g1 : g0;
            m_addr    = w ? a1 : a0;
            issue_cyc = cyc + 1;
            done_cyc  = cyc + 2;
            free_at   = cyc + 3;
        end
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    // Called just after a falling edge: asserts reset mid-cycle and checks the outputs clear at once.
    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        #1;
        check_eq("rst_bus", obs_bundle(), 32'h0);
        check_eq("rst_cnt", 32'({cnt0, cnt1}), 32'h0);
        issue_cyc = -10; done_cyc = -10; free_at = 0;
        m_last = 1'b1; m_cnt0 = 0; m_cnt1 = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        int ack_cyc[$];
        int ack_who[$];
        int n_ack0, prev;

        @(negedge clk);
        reset_pulse();

        // Single write access from requester 0.
        step(1'b1, 1'b1, 2'd2, 8'h03, 1'b0, 1'b0, 2'd0, 8'h00);
        check_eq("r31_idle_busy", 32'(busy), 32'h0);
        step(1'b1, 1'b1, 2'd2, 8'h03, 1'b0, 1'b0, 2'd0, 8'h00);
        check_eq("r31_issue", 32'({mem_run, mem_op, mem_reg, mem_addr, busy}), 32'({12'hE03, 1'b1}));
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
        check_eq("r31_done", 32'({ack0, ack1, mem_run, busy}), 32'b1001);
        idle_step();
        check_eq("r31_after", 32'(busy), 32'h0);

        // Both requesters held: grants alternate, acks three cycles apart.
        reset_pulse();
        for (int i = 0; i < 13; i++) begin
            step(1'b1, 1'b0, 2'd1, 8'h11, 1'b1, 1'b1, 2'd3, 8'h22);
            if (ack0 || ack1) begin
                ack_cyc.push_back(cyc);
                ack_who.push_back(int'(ack1));
            end
        end
        check_eq("r32_nacks", 32'(ack_cyc.size() >= 4), 32'h1);
        for (int i = 0; i < 4 && i < ack_who.size(); i++) begin
            check_eq("r32_owner", 32'(ack_who[i]), 32'(i % 2));
            if (i > 0) check_eq("r32_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        end
        idle_step();
        idle_step();

        // Requester 1 drops its request and changes payload after capture.
        reset_pulse();
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd1, 8'h5A);
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd3, 8'hFF);
        check_eq("r33_issue_addr", 32'({mem_run, mem_addr}), 32'h15A);
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd3, 8'hFF);
        check_eq("r33_done", 32'({ack1, mem_addr, mem_reg}), 32'({1'b1, 8'h5A, 2'd1}));
        idle_step();

        // Reset while requester 0 is in ISSUE; afterwards requester 0 wins contention again.
        reset_pulse();
        step(1'b1, 1'b0, 2'd0, 8'h40, 1'b0, 1'b0, 2'd0, 8'h00);
        step(1'b1, 1'b0, 2'd0, 8'h40, 1'b0, 1'b0, 2'd0, 8'h00);
        check_eq("r34_inflight", 32'({mem_run, gnt0}), 32'b11);
        reset_pulse();
        step(1'b1, 1'b0, 2'd1, 8'h41, 1'b1, 1'b1, 2'd2, 8'h42);
        check_eq("r34_no_ack", 32'({ack0, ack1}), 32'h0);
        step(1'b1, 1'b0, 2'd1, 8'h41, 1'b1, 1'b1, 2'd2, 8'h42);
        check_eq("r34_gnt", 32'({gnt0, gnt1}), 32'b10);
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
        idle_step();

        // Requester 0 held for 260 accesses: counters and back-to-back spacing.
        reset_pulse();
        n_ack0 = 0;
        prev   = -1;
        for (int i = 0; i < 1000 && n_ack0 < 260; i++) begin
            step(1'b1, 1'($urandom), 2'($urandom), 8'($urandom), 1'b0, 1'b0, 2'd0, 8'h00);
            if (ack0) begin
                if (prev >= 0 && n_ack0 < 5) check_eq("r36_gap", 32'(cyc - prev), 32'd3);
                prev = cyc;
                n_ack0++;
            end
        end
        check_eq("r35_acks", 32'(n_ack0), 32'd260);
        idle_step();
`ifdef MEM_ARB_PERF_EN
        check_eq("r35_cnt", 32'({cnt0, cnt1}), 32'({8'd255, 8'd0}));
`else
        check_eq("r35_cnt", 32'({cnt0, cnt1}), 32'h0);
`endif

        // Randomized traffic with occasional asynchronous resets.
        reset_pulse();
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 2) != 0), 1'($urandom), 2'($urandom), 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom), 2'($urandom), 8'($urandom));
            if ($urandom_range(0, 79) == 0) reset_pulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
